seq_bit_serializer: RTL and testbench

Parallel-to-serial bit feeder that sits directly upstream of the Moore 11011 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them onto a single-bit stream, one bit per clock, on the detector's `in` input. A one-word holding buffer lets back-to-back words stream without gaps. When no word is available, the stream idles at a fixed level.

---
 rtl/seq_bit_serializer.sv | 134 +++++++++++++
 tb/tb_seq_bit_serializer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//
// Parallel-to-serial bit feeder for the Moore 11011 sequence detector.
// WIDTH-bit words arrive over a valid/ready handshake. They are staged in a
// one-word holding buffer and then shifted out one bit per clock on ser_out.
// When a word is waiting in the buffer at the last bit of the current word,
// it is loaded directly. Back-to-back words therefore stream with no gap.
// When no word is available, ser_out rests at IDLE_BIT.
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: din[WIDTH-1] is sent first; 0: din[0] is sent first
//   IDLE_BIT   level driven on ser_out while no word is being shifted
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous, active-low reset
//   din          word to serialize, captured on an accept edge
//   din_valid    producer has a word on din
//   din_ready    holding buffer is empty (combinational)
//   ser_out      registered serial bit stream
//   ser_busy     high while a word is being shifted
//   frame_start  high during the cycle ser_out carries bit 0 of a word
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_busy,
    output logic             frame_start
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             frame_start_q, frame_start_d;

    logic             accept;
    logic             at_last;
    logic             load;
    logic [WIDTH-1:0] sh_shifted;

    // Reset forces din_ready low so no word can be accepted during reset.
    assign din_ready = rst && !hold_valid_q;
    assign accept    = din_valid && din_ready;
    assign at_last   = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    // Accept needs an empty buffer and load needs a full one, so the two
    // never collide on hold.
    assign load      = hold_valid_q && ((state_q == ST_IDLE) || at_last);

    // The bit on ser_out is always taken from the output end of sh; shifting
    // moves the next bit into that position.
    assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        frame_start_d = 1'b0;

        if (accept) begin
            hold_d       = din;
            hold_valid_d = 1'b1;
        end

        if (load) begin
            sh_d          = hold_q;
            cnt_d         = '0;
            state_d       = ST_SHIFT;
            hold_valid_d  = 1'b0;
            frame_start_d = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (cnt_q != CNT_LAST) begin
                sh_d  = sh_shifted;
                cnt_d = cnt_q + CW'(1);
            end else begin
                state_d = ST_IDLE;
            end
        end

        // ser_out is registered from the next-state view so that the bit
        // appears in the same cycle that sh holds it.
        if (state_d == ST_SHIFT) begin
            ser_out_d = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
        end else begin
            ser_out_d = IDLE_BIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            sh_q          <= '0;
            cnt_q         <= '0;
            ser_out_q     <= IDLE_BIT;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            ser_out_q     <= ser_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_busy    = (state_q == ST_SHIFT);
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
//
// Directed bench for seq_bit_serializer. Three instances share clk and rst:
//   dut0: WIDTH=8, MSB_FIRST=1, IDLE_BIT=0 (main scenarios)
//   dut1: WIDTH=8, MSB_FIRST=0, IDLE_BIT=0 (LSB-first ordering)
//   dut2: WIDTH=8, MSB_FIRST=1, IDLE_BIT=1 (idle level, never fed)
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// that same point, which reflects the state after that edge.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

    logic       clk;
    logic       rst;

    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       ser_out;
    logic       ser_busy;
    logic       frame_start;

    logic [7:0] din1;
    logic       din_valid1;
    logic       din_ready1;
    logic       ser_out1;
    logic       ser_busy1;
    logic       frame_start1;

    logic [7:0] din2;
    logic       din_valid2;
    logic       din_ready2;
    logic       ser_out2;
    logic       ser_busy2;
    logic       frame_start2;

    int checks;
    int errors;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .ser_out     (ser_out),
        .ser_busy    (ser_busy),
        .frame_start (frame_start)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .din         (din1),
        .din_valid   (din_valid1),
        .din_ready   (din_ready1),
        .ser_out     (ser_out1),
        .ser_busy    (ser_busy1),
        .frame_start (frame_start1)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .din         (din2),
        .din_valid   (din_valid2),
        .din_ready   (din_ready2),
        .ser_out     (ser_out2),
        .ser_busy    (ser_busy2),
        .frame_start (frame_start2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (ser_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ser_out got=%b want=0", ser_out);
        end
        checks++;
        if (ser_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ser_busy got=%b want=0", ser_busy);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_start got=%b want=0", frame_start);
        end
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_din_ready got=%b want=0", din_ready);
        end
        checks++;
        if (ser_out2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_bit1 got=%b want=1", ser_out2);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b want=1", din_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_single;
        logic [7:0] word;
        logic [4:0] hist;
        int         det_hits;
        word     = 8'b11011000;
        hist     = 5'b0;
        det_hits = 0;
        din       = word;
        din_valid = 1'b1;
        tick();                         // E0: accept
        din_valid = 1'b0;
        checks++;
        if (din_ready !== 1'b0 || ser_busy !== 1'b0 || ser_out !== 1'b0) begin
            errors++;
            $display("FAIL single_accept ready=%b busy=%b ser=%b want 0/0/0",
                     din_ready, ser_busy, ser_out);
        end
        for (int k = 0; k < 8; k++) begin
            tick();                     // E(1+k)
            checks++;
            if (ser_out !== word[7-k] || ser_busy !== 1'b1 ||
                frame_start !== (k == 0)) begin
                errors++;
                $display("FAIL single_bit%0d ser=%b busy=%b fs=%b want %b/1/%b",
                         k, ser_out, ser_busy, frame_start, word[7-k], (k == 0));
            end
            hist = {hist[3:0], ser_out};
            if (hist == 5'b11011) det_hits++;
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_after got=%b want=1", din_ready);
        end
        tick();                         // E9: back to idle
        checks++;
        if (ser_out !== 1'b0 || ser_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle ser=%b busy=%b want 0/0", ser_out, ser_busy);
        end
        hist = {hist[3:0], ser_out};
        if (hist == 5'b11011) det_hits++;
        checks++;
        if (det_hits != 1) begin
            errors++;
            $display("FAIL single_detector hits=%0d want=1", det_hits);
        end
        $display("test_single word=%h detector_hits=%0d", word, det_hits);
    endtask

    task automatic test_back_to_back;
        logic [15:0] stream;
        stream    = {8'hDB, 8'h6C};
        din       = 8'hDB;
        din_valid = 1'b1;
        tick();                         // E0: accept 0xDB
        din       = 8'h6C;              // accepted at E2 once ready rises
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 1) begin
                checks++;
                if (din_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_accept ready=%b want=0", din_ready);
                end
                din_valid = 1'b0;
            end
            checks++;
            if (ser_out !== stream[15-i] || ser_busy !== 1'b1 ||
                frame_start !== (i == 0 || i == 8)) begin
                errors++;
                $display("FAIL b2b_bit%0d ser=%b busy=%b fs=%b want %b/1/%b",
                         i, ser_out, ser_busy, frame_start, stream[15-i],
                         (i == 0 || i == 8));
            end
        end
        tick();
        checks++;
        if (ser_out !== 1'b0 || ser_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle ser=%b busy=%b want 0/0", ser_out, ser_busy);
        end
        $display("test_back_to_back stream=%h", stream);
    endtask

    task automatic test_lsb_first;
        logic [7:0] word;
        logic [7:0] expect_bits;
        word        = 8'b00011011;
        expect_bits = 8'b11011000;      // transmitted order, first bit at [7]
        din1        = word;
        din_valid1  = 1'b1;
        tick();
        din_valid1  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (ser_out1 !== expect_bits[7-k] || ser_busy1 !== 1'b1 ||
                frame_start1 !== (k == 0)) begin
                errors++;
                $display("FAIL lsb_bit%0d ser=%b busy=%b fs=%b want %b/1/%b",
                         k, ser_out1, ser_busy1, frame_start1, expect_bits[7-k],
                         (k == 0));
            end
        end
        tick();
        checks++;
        if (ser_out1 !== 1'b0 || ser_busy1 !== 1'b0 || din_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL lsb_idle ser=%b busy=%b ready=%b want 0/0/1",
                     ser_out1, ser_busy1, din_ready1);
        end
        $display("test_lsb_first word=%h", word);
    endtask

    task automatic test_backpressure;
        logic [15:0] stream;
        logic        want_ready;
        stream    = {8'hA1, 8'h3C};
        din       = 8'hA1;
        din_valid = 1'b1;
        tick();                         // E0: accept 0xA1
        for (int c = 0; c < 17; c++) begin
            // Inputs for edge E(c+1)
            if (c == 0) begin
                din = 8'hFF; din_valid = 1'b1;          // buffer full: ignored
            end else if (c == 1) begin
                din = 8'h3C; din_valid = 1'b1;          // accepted at E2
            end else if (c <= 7) begin
                din = 8'(c * 37 + 5); din_valid = 1'b1; // buffer full: ignored
            end else begin
                din_valid = 1'b0;
            end
            tick();
            want_ready = (c == 0) || (c >= 8);
            checks++;
            if (din_ready !== want_ready) begin
                errors++;
                $display("FAIL bp_ready_c%0d got=%b want=%b", c, din_ready, want_ready);
            end
            checks++;
            if (c < 16) begin
                if (ser_out !== stream[15-c] || ser_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_bit%0d ser=%b busy=%b want %b/1",
                             c, ser_out, ser_busy, stream[15-c]);
                end
            end else begin
                if (ser_out !== 1'b0 || ser_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_idle ser=%b busy=%b want 0/0", ser_out, ser_busy);
                end
            end
        end
        $display("test_backpressure stream=%h", stream);
    endtask

    task automatic test_reset_midword;
        din       = 8'hF0;
        din_valid = 1'b1;
        tick();                         // E0: accept 0xF0
        for (int c = 0; c < 4; c++) begin
            if (c < 2) begin
                din = 8'h0F; din_valid = 1'b1;  // lands in hold at E2
            end else begin
                din_valid = 1'b0;
            end
            tick();
        end
        // After E4: bit 3 of 0xF0 on the line, 0x0F waiting in hold
        checks++;
        if (ser_out !== 1'b1 || ser_busy !== 1'b1 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre ser=%b busy=%b ready=%b want 1/1/0",
                     ser_out, ser_busy, din_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready_low got=%b want=0", din_ready);
        end
        tick();                         // reset edge
        checks++;
        if (ser_out !== 1'b0 || ser_busy !== 1'b0 || frame_start !== 1'b0 ||
            din_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after ser=%b busy=%b fs=%b ready=%b want 0/0/0/0",
                     ser_out, ser_busy, frame_start, din_ready);
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (ser_out !== 1'b0 || ser_busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_discard_c%0d ser=%b busy=%b want 0/0",
                         c, ser_out, ser_busy);
            end
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready_after got=%b want=1", din_ready);
        end
        $display("test_reset_midword done");
    endtask

    task automatic test_idle_level;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (ser_out2 !== 1'b1 || ser_busy2 !== 1'b0 ||
                frame_start2 !== 1'b0 || din_ready2 !== 1'b1) begin
                errors++;
                $display("FAIL idle_c%0d ser=%b busy=%b fs=%b ready=%b want 1/0/0/1",
                         c, ser_out2, ser_busy2, frame_start2, din_ready2);
            end
        end
        $display("test_idle_level done");
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        din1       = 8'h00;
        din_valid1 = 1'b0;
        din2       = 8'h00;
        din_valid2 = 1'b0;

        test_reset();
        test_idle_level();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_backpressure();
        test_reset_midword();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
